// File: rtl/alu_seq.sv
// Sequential MIPS-style ALU behind a valid/ready handshake.
// Single-cycle ops finish one cycle after acceptance. With ALU_SEQ_MDU_EN defined, the block
// also has an iterative multiply/divide unit with HI/LO registers. Each multiply or divide
// takes WIDTH cycles in EXEC. Without the macro, the multiply/divide and HI/LO functs are
// unrecognised and return 0.
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       ALU_control,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  input  logic [SHW-1:0]   shamt,
  input  logic [15:0]      immediate,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic             sig_branch,
  output logic             busy
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;

  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnXor   = 6'b100110;
  localparam logic [5:0] FnNor   = 6'b100111;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnSll   = 6'b000000;
  localparam logic [5:0] FnSrl   = 6'b000010;
  localparam logic [5:0] FnSra   = 6'b000011;
`ifdef ALU_SEQ_MDU_EN
  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMflo  = 6'b010010;
`endif

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] alu_result_q;
  logic             sig_branch_q;
  logic [WIDTH-1:0] sc_result;
  logic             sc_branch;
  logic [WIDTH-1:0] imm_ext;

`ifdef ALU_SEQ_MDU_EN
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [SHW-1:0]     cnt_q;
  // Upper half: accumulator or remainder. Lower half: multiplier or dividend/quotient.
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   opb_q;
  logic               is_div_q;
  logic               neg_lo_q, neg_hi_q;
  logic               mdu_start, mdu_div, mdu_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] step_prod, fin_prod;
  logic [WIDTH:0]     add_sum, shifted, diff;
  logic [WIDTH-1:0]   fin_hi, fin_lo, fin_quo, fin_rem;
`endif

  assign imm_ext    = WIDTH'($signed(immediate));
  assign in_ready   = (state_q == StIdle) && !out_valid && !rst;
  assign out_valid  = (state_q == StDone);
  assign ALU_result = alu_result_q;
  assign sig_branch = sig_branch_q;
`ifdef ALU_SEQ_MDU_EN
  assign busy = (state_q == StExec);
`else
  assign busy = 1'b0;
`endif

  // Decode the request into a single-cycle result or a multiply/divide start.
  always_comb begin
    sc_result = '0;
    sc_branch = 1'b0;
`ifdef ALU_SEQ_MDU_EN
    mdu_start  = 1'b0;
    mdu_div    = 1'b0;
    mdu_signed = 1'b0;
`endif
    case (opcode)
      OpRtype: begin
        case (ALU_control)
          FnAdd:   sc_result = rs_content + rt_content;
          FnSub:   sc_result = rs_content - rt_content;
          FnAnd:   sc_result = rs_content & rt_content;
          FnOr:    sc_result = rs_content | rt_content;
          FnXor:   sc_result = rs_content ^ rt_content;
          FnNor:   sc_result = ~(rs_content | rt_content);
          FnSlt:   sc_result = {{(WIDTH-1){1'b0}}, $signed(rs_content) < $signed(rt_content)};
          FnSll:   sc_result = rt_content << shamt;
          FnSrl:   sc_result = rt_content >> shamt;
          FnSra:   sc_result = WIDTH'($signed(rt_content) >>> shamt);
`ifdef ALU_SEQ_MDU_EN
          FnMult:  begin mdu_start = 1'b1; mdu_signed = 1'b1; end
          FnMultu: mdu_start = 1'b1;
          FnDiv:   begin mdu_start = 1'b1; mdu_div = 1'b1; mdu_signed = 1'b1; end
          FnDivu:  begin mdu_start = 1'b1; mdu_div = 1'b1; end
          FnMfhi:  sc_result = hi_q;
          FnMflo:  sc_result = lo_q;
`endif
          default: sc_result = '0;
        endcase
      end
      OpLw, OpSw, OpAddi: sc_result = rs_content + imm_ext;
      OpBeq: begin
        sc_result = rs_content - rt_content;
        sc_branch = (rs_content == rt_content);
      end
      OpBne: begin
        sc_result = rs_content - rt_content;
        sc_branch = (rs_content != rt_content);
      end
      default: sc_result = '0;
    endcase
  end

`ifdef ALU_SEQ_MDU_EN
  // One multiply (shift-add) or divide (restoring) step, plus final sign correction.
  always_comb begin
    a_abs   = (mdu_signed && rs_content[WIDTH-1]) ? ('0 - rs_content) : rs_content;
    b_abs   = (mdu_signed && rt_content[WIDTH-1]) ? ('0 - rt_content) : rt_content;
    add_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opb_q : '0)};
    shifted = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    diff    = shifted - {1'b0, opb_q};
    if (is_div_q) begin
      // Bit WIDTH of diff set means the trial subtraction borrowed: restore.
      if (!diff[WIDTH]) step_prod = {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
      else              step_prod = {shifted[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    end else begin
      step_prod = {add_sum, prod_q[WIDTH-1:1]};
    end
    fin_prod = neg_lo_q ? ('0 - step_prod) : step_prod;
    fin_quo  = neg_lo_q ? ('0 - step_prod[WIDTH-1:0]) : step_prod[WIDTH-1:0];
    fin_rem  = neg_hi_q ? ('0 - step_prod[2*WIDTH-1:WIDTH]) : step_prod[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      fin_hi = fin_rem;
      fin_lo = fin_quo;
    end else begin
      fin_hi = fin_prod[2*WIDTH-1:WIDTH];
      fin_lo = fin_prod[WIDTH-1:0];
    end
  end
`endif

  // Control FSM with registered result, branch flag and multiply/divide state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      alu_result_q <= '0;
      sig_branch_q <= 1'b0;
`ifdef ALU_SEQ_MDU_EN
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            alu_result_q <= sc_result;
            sig_branch_q <= sc_branch;
            state_q      <= StDone;
`ifdef ALU_SEQ_MDU_EN
            if (mdu_start) begin
              state_q  <= StExec;
              cnt_q    <= '0;
              is_div_q <= mdu_div;
              if (mdu_div && (rt_content == '0)) begin
                // Unsigned restoring on the raw dividend gives LO = all ones, HI = rs.
                prod_q   <= {{WIDTH{1'b0}}, rs_content};
                opb_q    <= '0;
                neg_lo_q <= 1'b0;
                neg_hi_q <= 1'b0;
              end else begin
                prod_q   <= {{WIDTH{1'b0}}, a_abs};
                opb_q    <= b_abs;
                neg_lo_q <= mdu_signed && (rs_content[WIDTH-1] ^ rt_content[WIDTH-1]);
                neg_hi_q <= mdu_signed && mdu_div && rs_content[WIDTH-1];
              end
            end
`endif
          end
        end
`ifdef ALU_SEQ_MDU_EN
        StExec: begin
          prod_q <= step_prod;
          cnt_q  <= cnt_q + SHW'(1);
          if (cnt_q == SHW'(WIDTH - 1)) begin
            hi_q         <= fin_hi;
            lo_q         <= fin_lo;
            alu_result_q <= fin_lo;
            sig_branch_q <= 1'b0;
            state_q      <= StDone;
          end
        end
`endif
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq at WIDTH = 32.
module tb_alu_seq;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_MULU = 6'b011001;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_DIVU = 6'b011011;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_BAD  = 6'b111111;

`ifdef ALU_SEQ_MDU_EN
  localparam int MLAT = 33;
`else
  localparam int MLAT = 1;
`endif

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, sig_branch, busy;
  logic [5:0]  opcode, ALU_control;
  logic [31:0] rs_content, rt_content, ALU_result;
  logic [4:0]  shamt;
  logic [15:0] immediate;

  logic [32:0] sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .ALU_control(ALU_control), .rs_content(rs_content), .rt_content(rt_content),
    .shamt(shamt), .immediate(immediate), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_result(ALU_result), .sig_branch(sig_branch), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, check latency from the accepting edge, then drain after hold cycles.
  task automatic do_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic [15:0] imm, input logic [31:0] er, input logic eb,
                       input int lat, input int hold);
    logic [32:0] exp_v;
    int cyc;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    opcode = op; ALU_control = fn; rs_content = a; rt_content = b;
    shamt = sh; immediate = imm; in_valid = 1'b1;
    sb_q.push_back({eb, er});
    @(negedge clk);
    in_valid = 1'b0;
    rs_content = $urandom; rt_content = $urandom;
    check({tag, "_busy"}, 64'(busy), (lat > 1) ? 64'd1 : 64'd0);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    exp_v = sb_q.pop_front();
    check({tag, "_result"}, 64'(ALU_result), 64'(exp_v[31:0]));
    check({tag, "_branch"}, 64'(sig_branch), 64'(exp_v[32]));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; opcode = OP_R; ALU_control = FN_ADD;
      rs_content = $urandom; rt_content = $urandom;
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_hold_result"}, 64'(ALU_result), 64'(exp_v[31:0]));
      check({tag, "_hold_branch"}, 64'(sig_branch), 64'(exp_v[32]));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = '0; ALU_control = '0;
    rs_content = '0; rt_content = '0; shamt = '0; immediate = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_result", 64'(ALU_result), 64'd0);
    check("rst_branch", 64'(sig_branch), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    do_op("sw",      OP_SW,   6'd0,    32'd15, 32'd0, 5'd0, 16'd19, 32'd34, 1'b0, 1, 0);
    do_op("beq_eq",  OP_BEQ,  6'd0,    32'd23, 32'd23, 5'd0, 16'd0, 32'd0, 1'b1, 1, 0);
    do_op("bne_ne",  OP_BNE,  6'd0,    32'd1, 32'd35, 5'd0, 16'd0, 32'hFFFF_FFDE, 1'b1, 1, 0);
    do_op("beq_ne",  OP_BEQ,  6'd0,    32'd1, 32'd2, 5'd0, 16'd0, 32'hFFFF_FFFF, 1'b0, 1, 0);
    do_op("bne_eq",  OP_BNE,  6'd0,    32'd7, 32'd7, 5'd0, 16'd0, 32'd0, 1'b0, 1, 0);
    do_op("add_wrap", OP_R,   FN_ADD,  32'hFFFF_FFFF, 32'd1, 5'd0, 16'd0, 32'd0, 1'b0, 1, 0);
    do_op("sub",     OP_R,    FN_SUB,  32'd5, 32'd7, 5'd0, 16'd0, 32'hFFFF_FFFE, 1'b0, 1, 0);
    do_op("and",     OP_R,    FN_AND,  32'hF0F0_00FF, 32'h0FF0_F00F, 5'd0, 16'd0,
          32'h00F0_000F, 1'b0, 1, 0);
    do_op("or",      OP_R,    FN_OR,   32'hF0F0_00FF, 32'h0FF0_F00F, 5'd0, 16'd0,
          32'hFFF0_F0FF, 1'b0, 1, 0);
    do_op("xor_hold", OP_R,   FN_XOR,  32'hF0F0_00FF, 32'h0FF0_F00F, 5'd0, 16'd0,
          32'hFF00_F0F0, 1'b0, 1, 5);
    do_op("nor",     OP_R,    FN_NOR,  32'hF0F0_00FF, 32'h0FF0_F00F, 5'd0, 16'd0,
          32'h000F_0F00, 1'b0, 1, 0);
    do_op("slt_t",   OP_R,    FN_SLT,  32'hFFFF_FFFF, 32'd1, 5'd0, 16'd0, 32'd1, 1'b0, 1, 0);
    do_op("slt_f",   OP_R,    FN_SLT,  32'd1, 32'hFFFF_FFFF, 5'd0, 16'd0, 32'd0, 1'b0, 1, 0);
    do_op("sll",     OP_R,    FN_SLL,  32'd0, 32'h8000_0001, 5'd4, 16'd0, 32'h0000_0010,
          1'b0, 1, 0);
    do_op("srl",     OP_R,    FN_SRL,  32'd0, 32'h8000_0000, 5'd31, 16'd0, 32'd1, 1'b0, 1, 0);
    do_op("sra",     OP_R,    FN_SRA,  32'd0, 32'h8000_0000, 5'd4, 16'd0, 32'hF800_0000,
          1'b0, 1, 0);
    do_op("addi_neg", OP_ADDI, 6'd0,   32'd10, 32'd0, 5'd0, 16'hFFFF, 32'd9, 1'b0, 1, 0);
    do_op("lw_neg",  OP_LW,   6'd0,    32'h100, 32'd0, 5'd0, 16'h8000, 32'hFFFF_8100,
          1'b0, 1, 0);
    do_op("bad_op",  OP_BAD,  6'd0,    32'd3, 32'd4, 5'd0, 16'h1234, 32'd0, 1'b0, 1, 0);
    do_op("bad_fn",  OP_R,    FN_BAD,  32'd3, 32'd4, 5'd0, 16'd0, 32'd0, 1'b0, 1, 0);

`ifdef ALU_SEQ_MDU_EN
    do_op("mult",    OP_R, FN_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0, 16'd0, 32'hFFFF_FFEB, 1'b0,
          MLAT, 0);
    do_op("mfhi_m",  OP_R, FN_MFHI, 32'd0, 32'd0, 5'd0, 16'd0, 32'hFFFF_FFFF, 1'b0, 1, 0);
    do_op("multu",   OP_R, FN_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 16'd0, 32'd1, 1'b0,
          MLAT, 0);
    do_op("mfhi_mu", OP_R, FN_MFHI, 32'd0, 32'd0, 5'd0, 16'd0, 32'hFFFF_FFFE, 1'b0, 1, 0);
    do_op("div",     OP_R, FN_DIV,  32'hFFFF_FFF9, 32'd2, 5'd0, 16'd0, 32'hFFFF_FFFD, 1'b0,
          MLAT, 0);
    do_op("mfhi_d",  OP_R, FN_MFHI, 32'd0, 32'd0, 5'd0, 16'd0, 32'hFFFF_FFFF, 1'b0, 1, 0);
    do_op("divu_z",  OP_R, FN_DIVU, 32'd5, 32'd0, 5'd0, 16'd0, 32'hFFFF_FFFF, 1'b0, MLAT, 0);
    do_op("mfhi_dz", OP_R, FN_MFHI, 32'd0, 32'd0, 5'd0, 16'd0, 32'd5, 1'b0, 1, 0);
    do_op("div_z",   OP_R, FN_DIV,  32'hFFFF_FFF9, 32'd0, 5'd0, 16'd0, 32'hFFFF_FFFF, 1'b0,
          MLAT, 0);
    do_op("mfhi_sz", OP_R, FN_MFHI, 32'd0, 32'd0, 5'd0, 16'd0, 32'hFFFF_FFF9, 1'b0, 1, 0);
    do_op("div_ovf", OP_R, FN_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 16'd0, 32'h8000_0000,
          1'b0, MLAT, 0);
    do_op("mfhi_ov", OP_R, FN_MFHI, 32'd0, 32'd0, 5'd0, 16'd0, 32'd0, 1'b0, 1, 0);
    do_op("mflo_ov", OP_R, FN_MFLO, 32'd0, 32'd0, 5'd0, 16'd0, 32'h8000_0000, 1'b0, 1, 0);
`else
    do_op("mult_off", OP_R, FN_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0, 16'd0, 32'd0, 1'b0, MLAT, 0);
    do_op("mfhi_off", OP_R, FN_MFHI, 32'd0, 32'd0, 5'd0, 16'd0, 32'd0, 1'b0, 1, 0);
`endif

    // Abort a divu with reset 10 cycles after acceptance.
    @(negedge clk);
    opcode = OP_R; ALU_control = FN_DIVU; rs_content = 32'd100; rt_content = 32'd7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    do_op("mflo_abort", OP_R, FN_MFLO, 32'd0, 32'd0, 5'd0, 16'd0, 32'd0, 1'b0, 1, 0);
    do_op("mfhi_abort", OP_R, FN_MFHI, 32'd0, 32'd0, 5'd0, 16'd0, 32'd0, 1'b0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
